// File: rtl/norm_shift_unit.sv
// norm_shift_unit: multi-cycle 32-bit normalizer, one bit per cycle.
// Define NORM_SIGNED_EN to honor is_signed (redundant-sign-bit count).
module norm_shift_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src1,
    input  logic        is_signed,
    output logic        busy,
    output logic        done,
    output logic [31:0] norm_out,
    output logic [5:0]  shamt,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] w;
    logic [5:0]  cnt;
    logic        hit;
    logic        accept;

    assign accept = start & ((state == IDLE) | (state == DONE));

`ifdef NORM_SIGNED_EN
    logic mode;

    // signed mode stops once the top two bits differ
    assign hit = mode ? (w[31] ^ w[30]) : w[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0;
        end else if (accept) begin
            mode <= is_signed;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign hit = w[31];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            w        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            norm_out <= '0;
            shamt    <= '0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                w     <= src1;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= BUSY;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    BUSY: begin
                        if (w == 32'd0) begin
                            norm_out <= '0;
                            shamt    <= 6'd32;
                            zero     <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else if (hit) begin
                            norm_out <= w;
                            shamt    <= cnt;
                            zero     <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            w   <= w << 1;
                            cnt <= cnt + 6'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_norm_shift_unit.sv
// tb_norm_shift_unit: directed and random checks of norm_shift_unit
// against an arithmetic leading-zero / sign-bit reference.
module tb_norm_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src1;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [31:0] norm_out;
    logic [5:0]  shamt;
    logic        zero;

    int checks = 0;
    int errors = 0;

    norm_shift_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src1      (src1),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .norm_out  (norm_out),
        .shamt     (shamt),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int bitlen(input logic [31:0] x);
        int n = 0;
        logic [31:0] t = x;
        while (t != 0) begin
            t = t >> 1;
            n++;
        end
        return n;
    endfunction

    // Reference: unsigned = count leading zeros; signed = leading sign copies - 1
    task automatic ref_norm(input logic [31:0] v, input bit sg,
                            output logic [31:0] n, output int sh, output bit z);
        bit eff = 1'b0;
`ifdef NORM_SIGNED_EN
        eff = sg;
`endif
        if (v == 0) begin
            n = '0; sh = 32; z = 1'b1;
        end else begin
            z = 1'b0;
            if (eff)
                sh = (32 - bitlen(v[31] ? ~v : v)) - 1;
            else
                sh = 32 - bitlen(v);
            n = v << sh;
        end
    endtask

    task automatic go(input logic [31:0] s, input bit sg);
        start = 1'b1;
        src1 = s;
        is_signed = sg;
    endtask

    // Called at the negedge of cycle 0 with the request already driven.
    task automatic track(input logic [31:0] s, input bit sg, input string tag,
                         input int poke, input bit hold,
                         input logic [31:0] nxt);
        logic [31:0] en;
        int es, lat, cyc;
        bit ez, busy_ok;
        ref_norm(s, sg, en, es, ez);
        lat = ez ? 2 : es + 2;
        busy_ok = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = hold;
                src1 = hold ? nxt : $urandom;
                is_signed = hold ? 1'b0 : 1'($urandom);
            end
            if (poke > 0 && cyc == poke) begin
                start = 1'b1;
                src1 = ~s;
            end
            if (poke > 0 && cyc == poke + 1) start = 1'b0;
            if (busy !== (cyc < lat)) busy_ok = 1'b0;
        end while (done !== 1'b1 && cyc < 40);
        chk({tag, ".lat"}, cyc, lat);
        chk({tag, ".busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, ".norm"}, norm_out, en);
        chk({tag, ".shamt"}, {26'd0, shamt}, es);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
        if (!hold) begin
            @(negedge clk);
            chk({tag, ".pulse"}, {30'd0, done, busy}, 32'd0);
            chk({tag, ".held"}, norm_out, en);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        src1 = '0;
        is_signed = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.norm", norm_out, 32'd0);
        chk("rst.shamt", {26'd0, shamt}, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        go(32'h8000_0000, 1'b0);
        track(32'h8000_0000, 1'b0, "msb", 0, 1'b0, 0);
        chk("msb.k", {26'd0, shamt}, 32'd0);

        go(32'h0000_0001, 1'b0);
        track(32'h0000_0001, 1'b0, "one", 0, 1'b0, 0);
        chk("one.k", {26'd0, shamt}, 32'd31);

        go(32'h0, 1'b0);
        track(32'h0, 1'b0, "zero", 0, 1'b0, 0);
        chk("zero.k", {26'd0, shamt, zero}, {25'd0, 6'd32, 1'b1});

        go(32'hFFFF_F000, 1'b1);
        track(32'hFFFF_F000, 1'b1, "sneg", 0, 1'b0, 0);
`ifdef NORM_SIGNED_EN
        chk("sneg.k", {26'd0, shamt}, 32'd19);
`else
        chk("sneg.k", norm_out, 32'hFFFF_F000);
`endif

        go(32'h4000_0000, 1'b1);
        track(32'h4000_0000, 1'b1, "spos", 0, 1'b0, 0);
        go(32'h4000_0000, 1'b0);
        track(32'h4000_0000, 1'b0, "upos", 0, 1'b0, 0);
        chk("upos.k", {26'd0, shamt}, 32'd1);

        go(32'hFFFF_FFFF, 1'b1);
        track(32'hFFFF_FFFF, 1'b1, "m1", 0, 1'b0, 0);

        go(32'h0000_0100, 1'b0);
        track(32'h0000_0100, 1'b0, "poke", 6, 1'b0, 0);

        go(32'h0001_0000, 1'b0);
        track(32'h0001_0000, 1'b0, "b2b1", 0, 1'b1, 32'h0000_0F00);
        track(32'h0000_0F00, 1'b0, "b2b2", 0, 1'b0, 0);

        go(32'h0000_0100, 1'b0);
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mrst.out", {busy, done, zero, shamt}, 32'd0);
        chk("mrst.norm", norm_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (done || busy) seen = 1'b1;
            end
            chk("mrst.quiet", {31'd0, seen}, 32'd0);
        end
        go(32'h0000_0100, 1'b0);
        track(32'h0000_0100, 1'b0, "mrst.new", 0, 1'b0, 0);
        chk("mrst.k", {26'd0, shamt}, 32'd23);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] v;
            bit sg;
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) v = '0;
            if ($urandom_range(0, 1) == 1) v = ~v;
            sg = 1'($urandom);
            go(v, sg);
            track(v, sg, $sformatf("rnd%0d", i), 0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
